// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control-code encoding, execute-FSM state type and
//                the width of the control code. Also used by the ALU control
//                decoder, which drives alu_code_e values.
//  Contents    : ALU_CODE_W, alu_code_e, alu_state_e, is_shift_code()
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_CODE_W = 4;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_SLT = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } alu_state_e;

    // True for the three codes handled by the iterative shifter.
    function automatic logic is_shift_code(input logic [ALU_CODE_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb_core
//  Description : Single-cycle combinational ALU: AND/OR/ADD/SUB/SLT/XOR and
//                illegal-code detection. Shift codes are legal here but their
//                result comes from the iterative shifter in alu_exec_unit.
//  Ports       : code    in   ALU control code
//                a, b    in   operands
//                result  out  operation result (0 for shifts and illegal)
//                illegal out  code is not one of the supported codes
//  Revision    : 1.0  initial release
// ============================================================================
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_CODE_W-1:0] code,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic [WIDTH-1:0]      result,
    output logic                  illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (code)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_XOR: result = a ^ b;
            ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : ALU execute unit with valid/ready request and response
//                channels. Logic/arith ops complete in one cycle; shifts run
//                one bit per cycle under a two-state FSM.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                req_valid/req_ready        request handshake
//                req_code, req_a, req_b     code and operands (shamt = b[SHAMT_W-1:0])
//                rsp_valid/rsp_ready        response handshake
//                rsp_result, rsp_zero,      result, result==0 flag,
//                rsp_illegal                unsupported-code flag
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ALU_CODE_W-1:0] req_code,
    input  logic [WIDTH-1:0]      req_a,
    input  logic [WIDTH-1:0]      req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal
);

    localparam logic [SHAMT_W-1:0] c_one = SHAMT_W'(1);

    alu_state_e            r_state;
    alu_state_e            w_state_next;
    logic [WIDTH-1:0]      r_work;
    logic [SHAMT_W-1:0]    r_count;
    logic [ALU_CODE_W-1:0] r_code;
    logic                  r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_illegal;

    logic [WIDTH-1:0]      w_core_result;
    logic                  w_core_illegal;
    logic [SHAMT_W-1:0]    w_shamt;
    logic                  w_accept;
    logic                  w_is_shift;
    logic                  w_start_shift;
    logic                  w_shift_done;
    logic                  w_load;
    logic [WIDTH-1:0]      w_work_next;
    logic [WIDTH-1:0]      w_load_result;
    logic                  w_load_illegal;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .code    (req_code),
        .a       (req_a),
        .b       (req_b),
        .result  (w_core_result),
        .illegal (w_core_illegal)
    );

    assign w_shamt       = req_b[SHAMT_W-1:0];
    assign w_accept      = req_valid && req_ready;
    assign w_is_shift    = is_shift_code(req_code);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    // The last shift step produces the final value in the same cycle it loads.
    assign w_shift_done  = (r_state == SHIFT) && (r_count == c_one);
    assign w_load        = (w_accept && !w_start_shift) || w_shift_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_shift) w_state_next = SHIFT;
            SHIFT:   if (w_shift_done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Accept only when the output register is free or is being drained now,
    // so a completing shift never collides with an unaccepted response.
    always_comb begin
        req_ready = 1'b0;
        if (r_state == IDLE) begin
            req_ready = !r_rsp_valid || rsp_ready;
        end
    end

    // ---------------- Shift datapath ----------------
    always_comb begin
        w_work_next = r_work;
        case (r_code)
            ALU_SLL: w_work_next = {r_work[WIDTH-2:0], 1'b0};
            ALU_SRL: w_work_next = {1'b0, r_work[WIDTH-1:1]};
            ALU_SRA: w_work_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_work_next = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
            r_code  <= '0;
        end else if (w_start_shift) begin
            r_work  <= req_a;
            r_count <= w_shamt;
            r_code  <= req_code;
        end else if (r_state == SHIFT) begin
            r_work  <= w_work_next;
            r_count <= r_count - c_one;
        end
    end

    // ---------------- Response registers ----------------
    always_comb begin
        w_load_result  = w_core_result;
        w_load_illegal = w_core_illegal;
        if (w_shift_done) begin
            w_load_result  = w_work_next;
            w_load_illegal = 1'b0;
        end else if (w_is_shift) begin
            // Zero shift amount bypasses the shifter entirely.
            w_load_result  = req_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (w_load) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= w_load_result;
            r_rsp_zero    <= (w_load_result == '0);
            r_rsp_illegal <= w_load_illegal;
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;

endmodule
`default_nettype wire
